// File: rtl/regfile_seq_ctrl.sv
// Multi-cycle sequencer + ALU driving an 8x8 two-read/one-write register file.
// Macro: RSEQ_SAT_EN (saturating ADD/SUB).
// Ports: clk, rst (sync, active-high); instr_valid/instr_ready/instr handshake;
//   SA/SB read selects with Adata/Bdata; DS/Load/Ddata write port;
//   done pulse, result, flag_z, flag_c, illegal status.
module regfile_seq_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [AW-1:0] SA,
  output logic [AW-1:0] SB,
  input  logic [DW-1:0] Adata,
  input  logic [DW-1:0] Bdata,
  output logic [AW-1:0] DS,
  output logic          Load,
  output logic [DW-1:0] Ddata,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          flag_z,
  output logic          flag_c,
  output logic          illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t        r_state;
  logic [15:0]   r_instr;
  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_opb;

  logic [3:0]    w_in_op;
  logic          w_in_rd;
  logic [3:0]    w_op;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_add;
  logic [DW-1:0] w_sub;
  logic [DW-1:0] w_res;
  logic          w_c;
  logic          w_flags;
  logic          w_wr;

  assign w_in_op = instr[15:12];
  assign w_in_rd = (w_in_op >= 4'd2) &&
                   (w_in_op <= 4'd9);
  assign w_op    = r_instr[15:12];
  assign w_wr    = (w_op >= 4'd1) &&
                   (w_op <= 4'd9);

  assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
  assign w_diff = {1'b0, r_opa} - {1'b0, r_opb};

`ifdef RSEQ_SAT_EN
  assign w_add = w_sum[DW]  ? '1 : w_sum[DW-1:0];
  assign w_sub = w_diff[DW] ? '0 : w_diff[DW-1:0];
`else
  assign w_add = w_sum[DW-1:0];
  assign w_sub = w_diff[DW-1:0];
`endif

  // NOP and undefined ops keep result and flags as they were.
  always_comb begin
    w_res   = result;
    w_c     = flag_c;
    w_flags = 1'b0;
    case (w_op)
      4'd1: w_res = DW'(r_instr[7:0]);
      4'd2: w_res = r_opa;
      4'd3: begin
        w_res   = w_add;
        w_c     = w_sum[DW];
        w_flags = 1'b1;
      end
      4'd4: begin
        w_res   = w_sub;
        w_c     = w_diff[DW];
        w_flags = 1'b1;
      end
      4'd5: begin
        w_res   = r_opa & r_opb;
        w_c     = 1'b0;
        w_flags = 1'b1;
      end
      4'd6: begin
        w_res   = r_opa | r_opb;
        w_c     = 1'b0;
        w_flags = 1'b1;
      end
      4'd7: begin
        w_res   = r_opa ^ r_opb;
        w_c     = 1'b0;
        w_flags = 1'b1;
      end
      4'd8: begin
        w_res   = {r_opa[DW-2:0], 1'b0};
        w_c     = r_opa[DW-1];
        w_flags = 1'b1;
      end
      4'd9: begin
        w_res   = {1'b0, r_opa[DW-1:1]};
        w_c     = r_opa[0];
        w_flags = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      instr_ready <= 1'b1;
      SA          <= '0;
      SB          <= '0;
      DS          <= '0;
      Load        <= 1'b0;
      Ddata       <= '0;
      done        <= 1'b0;
      result      <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      Load <= 1'b0;
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr     <= instr;
            instr_ready <= 1'b0;
            illegal     <= (w_in_op > 4'd9);
            if (w_in_rd) begin
              // selects go out now so read data is valid during READ
              SA      <= AW'(instr[8:6]);
              SB      <= AW'(instr[5:3]);
              r_state <= S_READ;
            end else begin
              r_state <= S_EXEC;
            end
          end
        end
        S_READ: begin
          r_opa   <= Adata;
          r_opb   <= Bdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          result <= w_res;
          if (w_flags) begin
            flag_z <= (w_res == '0);
            flag_c <= w_c;
          end
          if (w_wr) begin
            Load  <= 1'b1;
            DS    <= AW'(r_instr[11:9]);
            Ddata <= w_res;
          end
          done    <= 1'b1;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          instr_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Bench for regfile_seq_ctrl: register file model, table vectors and
// hand-written sequences for held valid and mid-instruction reset.
module tb_regfile_seq_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic [AW-1:0] SA, SB, DS;
  logic [DW-1:0] Adata, Bdata, Ddata, result;
  logic          Load, done, flag_z, flag_c, illegal;

  regfile_seq_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr),
    .SA(SA), .SB(SB), .Adata(Adata), .Bdata(Bdata),
    .DS(DS), .Load(Load), .Ddata(Ddata),
    .done(done), .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rf [0:7];
  assign Adata = rf[SA];
  assign Bdata = rf[SB];
  always @(posedge clk) if (Load) rf[DS] <= Ddata;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  dd;
    logic        ld;
    logic        z;
    logic        c;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t v [18];

  function automatic logic [15:0] enc(input logic [3:0] op,
    input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd,
                                      input logic [7:0] imm);
    return {4'h1, rd, 1'b0, imm};
  endfunction

  function automatic vec_t mk(input logic [15:0] ins, input logic [7:0] dd,
    input logic ld, input logic z, input logic c, input logic ill,
    input int lat);
    vec_t t;
    t.ins = ins; t.dd = dd; t.ld = ld;
    t.z = z; t.c = c; t.ill = ill; t.lat = lat;
    return t;
  endfunction

  task automatic run(input vec_t t, input int idx);
    int k;
    logic seen;
    logic [3:0] op;
    op = t.ins[15:12];
    k = 0;
    while (!instr_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("v%0d_ready_idle", idx), 32'(instr_ready), 32'd1);
    instr = t.ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    k = 1;
    seen = 1'b0;
    while (k <= 10) begin
      if (k == 1 && op >= 4'd2 && op <= 4'd9) begin
        chk($sformatf("v%0d_SA", idx), 32'(SA), 32'(t.ins[8:6]));
        chk($sformatf("v%0d_SB", idx), 32'(SB), 32'(t.ins[5:3]));
      end
      if (instr_ready)
        chk($sformatf("v%0d_ready_busy", idx), 32'(instr_ready), 32'd0);
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
    if (!seen) begin
      chk($sformatf("v%0d_done_timeout", idx), 32'd0, 32'd1);
    end else begin
      chk($sformatf("v%0d_latency", idx), 32'(k), 32'(t.lat));
      chk($sformatf("v%0d_Load", idx), 32'(Load), 32'(t.ld));
      chk($sformatf("v%0d_Ddata", idx), 32'(Ddata), 32'(t.dd));
      if (t.ld)
        chk($sformatf("v%0d_DS", idx), 32'(DS), 32'(t.ins[11:9]));
      chk($sformatf("v%0d_flag_z", idx), 32'(flag_z), 32'(t.z));
      chk($sformatf("v%0d_flag_c", idx), 32'(flag_c), 32'(t.c));
      chk($sformatf("v%0d_illegal", idx), 32'(illegal), 32'(t.ill));
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", idx), 32'({Load, done}), 32'd0);
      chk($sformatf("v%0d_ready_after", idx), 32'(instr_ready), 32'd1);
      if (t.ld)
        chk($sformatf("v%0d_rf", idx), 32'(rf[t.ins[11:9]]), 32'(t.dd));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcnt, lcnt, rcnt;
    for (int i = 0; i < 8; i++) rf[i] = '0;

    v[0]  = mk(ldi(3'd1, 8'hF0), 8'hF0, 1, 0, 0, 0, 2);
    v[1]  = mk(ldi(3'd2, 8'h20), 8'h20, 1, 0, 0, 0, 2);
    v[2]  = mk(ldi(3'd3, 8'hA5), 8'hA5, 1, 0, 0, 0, 2);
`ifdef RSEQ_SAT_EN
    v[3]  = mk(enc(4'h3, 3'd4, 3'd1, 3'd2), 8'hFF, 1, 0, 1, 0, 3);
`else
    v[3]  = mk(enc(4'h3, 3'd4, 3'd1, 3'd2), 8'h10, 1, 0, 1, 0, 3);
`endif
    v[4]  = mk(ldi(3'd5, 8'h05), 8'h05, 1, 0, 1, 0, 2);
    v[5]  = mk(ldi(3'd6, 8'h05), 8'h05, 1, 0, 1, 0, 2);
    v[6]  = mk(enc(4'h4, 3'd7, 3'd5, 3'd6), 8'h00, 1, 1, 0, 0, 3);
`ifdef RSEQ_SAT_EN
    v[7]  = mk(enc(4'h4, 3'd7, 3'd5, 3'd1), 8'h00, 1, 1, 1, 0, 3);
    v[8]  = mk(ldi(3'd1, 8'h81), 8'h81, 1, 1, 1, 0, 2);
`else
    v[7]  = mk(enc(4'h4, 3'd7, 3'd5, 3'd1), 8'h15, 1, 0, 1, 0, 3);
    v[8]  = mk(ldi(3'd1, 8'h81), 8'h81, 1, 0, 1, 0, 2);
`endif
    v[9]  = mk(enc(4'h8, 3'd2, 3'd1, 3'd0), 8'h02, 1, 0, 1, 0, 3);
    v[10] = mk(enc(4'h9, 3'd2, 3'd1, 3'd0), 8'h40, 1, 0, 1, 0, 3);
    v[11] = mk(enc(4'h5, 3'd3, 3'd1, 3'd2), 8'h00, 1, 1, 0, 0, 3);
    v[12] = mk(enc(4'h6, 3'd3, 3'd1, 3'd2), 8'hC1, 1, 0, 0, 0, 3);
`ifdef RSEQ_SAT_EN
    v[13] = mk(enc(4'h7, 3'd4, 3'd4, 3'd1), 8'h7E, 1, 0, 0, 0, 3);
`else
    v[13] = mk(enc(4'h7, 3'd4, 3'd4, 3'd1), 8'h91, 1, 0, 0, 0, 3);
`endif
    v[14] = mk(enc(4'h2, 3'd5, 3'd3, 3'd0), 8'hC1, 1, 0, 0, 0, 3);
    v[15] = mk(enc(4'h0, 3'd6, 3'd1, 3'd2), 8'hC1, 0, 0, 0, 0, 2);
    v[16] = mk(enc(4'hC, 3'd6, 3'd1, 3'd2), 8'hC1, 0, 0, 0, 1, 2);
    v[17] = mk(ldi(3'd0, 8'h00), 8'h00, 1, 0, 0, 0, 2);

    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_pulses", 32'({Load, done}), 32'd0);
    chk("rst_flags", 32'({flag_z, flag_c, illegal}), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ports", 32'({SA, SB, DS, Ddata}), 32'd0);

    for (int i = 0; i < 17; i++) run(v[i], i);

    // undefined op with valid held high: re-accepted only after WRITE
    instr = enc(4'hC, 3'd1, 3'd1, 3'd1);
    instr_valid = 1'b1;
    dcnt = 0; lcnt = 0; rcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
      if (Load) lcnt++;
      if (instr_ready) rcnt++;
    end
    instr_valid = 1'b0;
    chk("held_done_count", 32'(dcnt), 32'd2);
    chk("held_load_count", 32'(lcnt), 32'd0);
    chk("held_ready_count", 32'(rcnt), 32'd2);
    chk("held_illegal", 32'(illegal), 32'd1);
    chk("held_ready_end", 32'(instr_ready), 32'd1);

    run(v[17], 17);

    // reset while ADD r4,r1,r2 is in EXEC
    instr = enc(4'h3, 3'd4, 3'd1, 3'd2);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", 32'(instr_ready), 32'd1);
    chk("mid_rst_pulses", 32'({Load, done}), 32'd0);
    chk("mid_rst_state", 32'({flag_z, flag_c, illegal, result}), 32'd0);
    chk("mid_rst_ports", 32'({SA, SB, DS, Ddata}), 32'd0);
    dcnt = 0; lcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcnt++;
      if (Load) lcnt++;
    end
    chk("mid_rst_no_done", 32'(dcnt), 32'd0);
    chk("mid_rst_no_load", 32'(lcnt), 32'd0);
`ifdef RSEQ_SAT_EN
    chk("mid_rst_r4_kept", 32'(rf[4]), 32'h7E);
`else
    chk("mid_rst_r4_kept", 32'(rf[4]), 32'h91);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
